// File: rtl/regfile_psr.sv
// ============================================================================
// regfile_psr : NREGS x DATA_W register file with write-to-read bypass and a
//               per-bit masked 5-bit processor status register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_psr #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        raddr_src,
    input  logic [3:0]        raddr_dest,
    output logic [DATA_W-1:0] rdata_src,
    output logic [DATA_W-1:0] rdata_dest,
    input  logic              wen,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        flags_in,
    input  logic [4:0]        flag_we,
    output logic [4:0]        psr,
    output logic              carry_in
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [4:0]        r_psr;
    logic [DATA_W-1:0] w_src_stored;
    logic [DATA_W-1:0] w_dest_stored;
    logic              w_byp_src;
    logic              w_byp_dest;

    // One flop group per register so the write decode stays per-entry and
    // out-of-range addresses (NREGS < 16) simply match nothing.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_regs[gi] <= '0;
            end else if (wen && (waddr == 4'(gi))) begin
                r_regs[gi] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psr <= 5'b00000;
        end else begin
            r_psr <= (r_psr & ~flag_we) | (flags_in & flag_we);
        end
    end

    always_comb begin
        w_src_stored  = '0;
        w_dest_stored = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (raddr_src == 4'(i)) begin
                w_src_stored = r_regs[i];
            end
            if (raddr_dest == 4'(i)) begin
                w_dest_stored = r_regs[i];
            end
        end
    end

    // Bypass is gated by rst_n so the read ports stay at zero during reset.
    assign w_byp_src  = rst_n && wen && (waddr == raddr_src);
    assign w_byp_dest = rst_n && wen && (waddr == raddr_dest);

    assign rdata_src  = w_byp_src  ? wdata : w_src_stored;
    assign rdata_dest = w_byp_dest ? wdata : w_dest_stored;
    assign psr        = r_psr;
    assign carry_in   = r_psr[4];

endmodule

`default_nettype wire

// File: tb/tb_regfile_psr.sv
// ============================================================================
// tb_regfile_psr : directed stimulus with a queued scoreboard; a negedge
//                  monitor pops and compares every queued expectation.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_psr;

    localparam int K_SRC  = 0;
    localparam int K_DEST = 1;
    localparam int K_PSR  = 2;
    localparam int K_CY   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  raddr_src, raddr_dest, waddr;
    logic [15:0] rdata_src, rdata_dest, wdata;
    logic        wen;
    logic [4:0]  flags_in, flag_we, psr;
    logic        carry_in;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        int          kind;
        logic [15:0] exp;
    } exp_t;

    exp_t sbq[$];

    regfile_psr #(.DATA_W(16), .NREGS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr_src  (raddr_src),
        .raddr_dest (raddr_dest),
        .rdata_src  (rdata_src),
        .rdata_dest (rdata_dest),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .flags_in   (flags_in),
        .flag_we    (flag_we),
        .psr        (psr),
        .carry_in   (carry_in)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach end of sequence");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [3:0] rs, input logic [3:0] rd,
                         input logic [4:0] fwe, input logic [4:0] fin);
        wen        = we;
        waddr      = wa;
        wdata      = wd;
        raddr_src  = rs;
        raddr_dest = rd;
        flag_we    = fwe;
        flags_in   = fin;
    endtask

    task automatic exp_push(input string nm, input int kind, input logic [15:0] v);
        exp_t e;
        e.name = nm;
        e.kind = kind;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    // Monitor: outputs are combinational/registered, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] act;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.kind)
                K_SRC:   act = rdata_src;
                K_DEST:  act = rdata_dest;
                K_PSR:   act = {11'b0, psr};
                default: act = {15'b0, carry_in};
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.exp, $time);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 5'h00, 5'h00);

        // Held in reset: every register reads 0, writes/flags/bypass ignored.
        for (int i = 0; i < 8; i++) begin
            cyc();
            drive(1'b1, 4'(2*i), 16'hFFFF, 4'(2*i), 4'(2*i+1), 5'h1F, 5'h1F);
            exp_push("rst_src",  K_SRC,  16'h0000);
            exp_push("rst_dest", K_DEST, 16'h0000);
            exp_push("rst_psr",  K_PSR,  16'h0000);
        end

        cyc(); rst_n = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd14, 5'h00, 5'h00);
        exp_push("post_rst_r0",  K_SRC,  16'h0000);
        exp_push("post_rst_r14", K_DEST, 16'h0000);
        exp_push("post_rst_psr", K_PSR,  16'h0000);
        exp_push("post_rst_cy",  K_CY,   16'h0000);

        // Write r3, read next cycle; neighbours untouched.
        cyc(); drive(1'b1, 4'd3, 16'hBEEF, 4'd2, 4'd4, 5'h00, 5'h00);
        exp_push("wr3_r2", K_SRC,  16'h0000);
        exp_push("wr3_r4", K_DEST, 16'h0000);
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd3, 4'd2, 5'h00, 5'h00);
        exp_push("rd_r3", K_SRC,  16'hBEEF);
        exp_push("rd_r2", K_DEST, 16'h0000);
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd4, 4'd3, 5'h00, 5'h00);
        exp_push("rd_r4",   K_SRC,  16'h0000);
        exp_push("rd_r3_d", K_DEST, 16'hBEEF);

        // Bypass on both ports over a previously stored value.
        cyc(); drive(1'b1, 4'd5, 16'h0001, 4'd0, 4'd0, 5'h00, 5'h00);
        cyc(); drive(1'b1, 4'd5, 16'h1234, 4'd5, 4'd5, 5'h00, 5'h00);
        exp_push("byp_src",  K_SRC,  16'h1234);
        exp_push("byp_dest", K_DEST, 16'h1234);
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd5, 4'd5, 5'h00, 5'h00);
        exp_push("r5_after_src",  K_SRC,  16'h1234);
        exp_push("r5_after_dest", K_DEST, 16'h1234);

        // Back-to-back writes to r5.
        cyc(); drive(1'b1, 4'd5, 16'hAAAA, 4'd5, 4'd3, 5'h00, 5'h00);
        exp_push("b2b1_src", K_SRC,  16'hAAAA);
        exp_push("b2b1_r3",  K_DEST, 16'hBEEF);
        cyc(); drive(1'b1, 4'd5, 16'h5555, 4'd3, 4'd5, 5'h00, 5'h00);
        exp_push("b2b2_r3",   K_SRC,  16'hBEEF);
        exp_push("b2b2_dest", K_DEST, 16'h5555);
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd5, 4'd5, 5'h00, 5'h00);
        exp_push("b2b_last", K_SRC,  16'h5555);

        // wen=0: no bypass, no write.
        cyc(); drive(1'b0, 4'd3, 16'hFFFF, 4'd3, 4'd3, 5'h00, 5'h00);
        exp_push("nowen_src",  K_SRC,  16'hBEEF);
        exp_push("nowen_dest", K_DEST, 16'hBEEF);
        cyc(); drive(1'b1, 4'd6, 16'h0C0C, 4'd3, 4'd6, 5'h00, 5'h00);
        exp_push("nowen_hold", K_SRC,  16'hBEEF);
        exp_push("byp_dest6",  K_DEST, 16'h0C0C);

        // Flag mask, no PSR bypass.
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 5'b10001, 5'b11111);
        exp_push("psr_nobyp", K_PSR, 16'h0000);
        exp_push("cy_nobyp",  K_CY,  16'h0000);
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 5'b00000, 5'b00000);
        exp_push("psr_mask", K_PSR, 16'h0011);
        exp_push("cy_mask",  K_CY,  16'h0001);
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 5'b00000, 5'b00000);
        exp_push("psr_hold", K_PSR, 16'h0011);

        // CMP-style: flags only, no register write.
        cyc(); drive(1'b0, 4'd3, 16'h0000, 4'd3, 4'd6, 5'b01011, 5'b01010);
        exp_push("cmp_pre_psr", K_PSR, 16'h0011);
        exp_push("cmp_r3",      K_SRC, 16'hBEEF);
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd3, 4'd6, 5'b00000, 5'b00000);
        exp_push("cmp_psr",  K_PSR,  16'h001A);
        exp_push("cmp_cy",   K_CY,   16'h0001);
        exp_push("cmp_r3b",  K_SRC,  16'hBEEF);
        exp_push("cmp_r6",   K_DEST, 16'h0C0C);

        // X on inputs with wen=0 and flag_we=0.
        cyc(); drive(1'b0, 4'bxxxx, 16'hxxxx, 4'd3, 4'd6, 5'b00000, 5'bxxxxx);
        exp_push("x_src", K_SRC, 16'hBEEF);
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd3, 4'd6, 5'b00000, 5'b00000);
        exp_push("x_psr",  K_PSR,  16'h001A);
        exp_push("x_r3",   K_SRC,  16'hBEEF);
        exp_push("x_r6",   K_DEST, 16'h0C0C);

        // Asynchronous reset between edges.
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd3, 4'd5, 5'h00, 5'h00);
        #1; rst_n = 1'b0;
        exp_push("async_src",  K_SRC,  16'h0000);
        exp_push("async_dest", K_DEST, 16'h0000);
        exp_push("async_psr",  K_PSR,  16'h0000);
        exp_push("async_cy",   K_CY,   16'h0000);

        // Release, set and clear carry.
        cyc(); rst_n = 1'b1;
        drive(1'b1, 4'd7, 16'h7777, 4'd7, 4'd3, 5'b10000, 5'b10000);
        exp_push("mw_byp7", K_SRC,  16'h7777);
        exp_push("mw_r3_0", K_DEST, 16'h0000);
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd7, 4'd7, 5'b10000, 5'b00000);
        exp_push("mw_r7",    K_SRC, 16'h7777);
        exp_push("cy_set",   K_CY,  16'h0001);
        cyc(); drive(1'b1, 4'd7, 16'hDEAD, 4'd7, 4'd7, 5'h00, 5'h00);
        exp_push("cy_clr",   K_CY,  16'h0000);
        exp_push("mw_dead",  K_SRC, 16'hDEAD);

        // Reset lands 1 ns before the edge carrying the r7 write.
        #8; rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        drive(1'b0, 4'd0, 16'h0, 4'd7, 4'd3, 5'h00, 5'h00);
        exp_push("mw_r7_dropped", K_SRC,  16'h0000);
        exp_push("mw_r3_clr",     K_DEST, 16'h0000);
        exp_push("mw_psr_clr",    K_PSR,  16'h0000);
        cyc(); drive(1'b1, 4'd7, 16'hCAFE, 4'd7, 4'd0, 5'h00, 5'h00);
        exp_push("first_wr_byp", K_SRC, 16'hCAFE);
        cyc(); drive(1'b0, 4'd0, 16'h0, 4'd7, 4'd7, 5'h00, 5'h00);
        exp_push("first_wr_src",  K_SRC,  16'hCAFE);
        exp_push("first_wr_dest", K_DEST, 16'hCAFE);

        cyc();
        @(negedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
